// File: rtl/blink_driver_pkg.sv
// Shared types and constants for the lock design.
// Blink FSM encoding, default timing and per-event blink counts.
package blink_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_state_t;

    localparam int BLINK_ON_CYCLES  = 5_000_000;
    localparam int BLINK_OFF_CYCLES = 5_000_000;

    localparam int ACCEPT_BLINKS = 1;
    localparam int REJECT_BLINKS = 3;
    localparam int UNLOCK_BLINKS = 2;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter with a zero flag.
// Counts down to zero and holds there until reloaded.
module down_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Reload has priority; otherwise decrement, never below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/blink_driver.sv
// Turns single-cycle event pulses into timed LED/buzzer blinks.
// IDLE -> ON/OFF alternation for `count` blinks, then a done pulse.
module blink_driver
    import blink_driver_pkg::*;
#(
    parameter int ON_CYCLES  = BLINK_ON_CYCLES,
    parameter int OFF_CYCLES = BLINK_OFF_CYCLES,
    parameter int CNT_W      = 24,
    parameter int N_W        = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           trig,
    input  logic [N_W-1:0] count,
    input  logic           abort,
    output logic           out,
    output logic           busy,
    output logic           done
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    blink_state_t     r_state;
    blink_state_t     w_state_nxt;
    logic [N_W-1:0]   r_rem;
    logic [N_W-1:0]   w_rem_nxt;
    logic             r_out;
    logic             r_busy;
    logic             r_done;
    logic             w_out_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_fin;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_zero;

    down_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // State, remaining-blink count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next state, timer reloads and blink bookkeeping; abort wins.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_load      = 1'b0;
        w_load_val  = ON_LOAD;
        w_fin       = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (trig && (count != '0)) begin
                        w_state_nxt = ST_ON;
                        w_rem_nxt   = count;
                        w_load      = 1'b1;
                        w_load_val  = ON_LOAD;
                    end
                end
                ST_ON: begin
                    if (w_zero) begin
                        if (r_rem == N_W'(1)) begin
                            w_state_nxt = ST_IDLE;
                            w_rem_nxt   = '0;
                            w_fin       = 1'b1;
                        end else begin
                            w_state_nxt = ST_OFF;
                            w_rem_nxt   = r_rem - N_W'(1);
                            w_load      = 1'b1;
                            w_load_val  = OFF_LOAD;
                        end
                    end
                end
                ST_OFF: begin
                    if (w_zero) begin
                        w_state_nxt = ST_ON;
                        w_load      = 1'b1;
                        w_load_val  = ON_LOAD;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = '0;
                end
            endcase
        end
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        w_out_nxt  = (w_state_nxt == ST_ON);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = w_fin;
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_blink_driver.sv
// Bench for blink_driver with ON=4, OFF=3.
// Expected per-cycle {out,busy,done} samples are queued at trigger time.
module tb_blink_driver;

    localparam int ON  = 4;
    localparam int OFF = 3;

    logic       clk;
    logic       rst_n;
    logic       trig;
    logic [2:0] count;
    logic       abort;
    logic       out;
    logic       busy;
    logic       done;

    int         n_chk;
    int         n_fail;
    logic [2:0] q[$];
    logic       last_busy;

    blink_driver #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .CNT_W      (24),
        .N_W        (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .trig  (trig),
        .count (count),
        .abort (abort),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic push_pat(input int n);
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < ON; i++) q.push_back(3'b110);
            if (b < n - 1)
                for (int i = 0; i < OFF; i++) q.push_back(3'b010);
        end
        q.push_back(3'b001);
    endtask

    task automatic cyc(input logic t, input logic [2:0] c,
                       input logic a);
        logic [2:0] exp;
        @(negedge clk);
        trig  = t;
        count = c;
        abort = a;
        if (rst_n) begin
            if (a) begin
                if (last_busy) q.delete();
            end else if (t && (c != 3'd0) && !last_busy) begin
                push_pat(int'(c));
            end
        end
        @(posedge clk);
        #1;
        trig  = 1'b0;
        count = 3'd0;
        abort = 1'b0;
        exp = (q.size() > 0) ? q.pop_front() : 3'b000;
        chk("obd", {29'd0, out, busy, done}, {29'd0, exp});
        last_busy = exp[1];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        last_busy = 1'b0;
        rst_n     = 1'b0;
        trig      = 1'b0;
        count     = 3'd0;
        abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {29'd0, out, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single blink
        idle(8);
        cyc(1'b1, 3'd1, 1'b0);
        idle(10);

        // three blinks
        cyc(1'b1, 3'd3, 1'b0);
        idle(22);

        // zero count ignored
        cyc(1'b1, 3'd0, 1'b0);
        idle(5);

        // retrigger during first ON is ignored
        cyc(1'b1, 3'd2, 1'b0);
        cyc(1'b0, 3'd0, 1'b0);
        cyc(1'b1, 3'd5, 1'b0);
        idle(15);

        // abort in second OFF phase
        cyc(1'b1, 3'd3, 1'b0);
        idle(12);
        cyc(1'b0, 3'd0, 1'b1);
        idle(5);

        // trig + abort together in IDLE
        cyc(1'b1, 3'd3, 1'b1);
        idle(5);

        // abort in IDLE alone
        cyc(1'b0, 3'd0, 1'b1);
        idle(2);

        // async reset mid ON phase
        cyc(1'b1, 3'd2, 1'b0);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", {31'd0, out}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        q.delete();
        last_busy = 1'b0;
        idle(2);
        rst_n = 1'b1;
        cyc(1'b1, 3'd1, 1'b0);
        idle(8);

        // max count
        cyc(1'b1, 3'd7, 1'b0);
        idle(50);

        chk("q_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
